// File: rtl/sci_alu_seq.sv
// rtl/sci_alu_seq.sv - clocked integer ALU with valid/ready handshake and iterative divider
module sci_alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             excep,
  output logic             err,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  localparam logic [WIDTH-1:0] W_VAL    = WIDTH'(WIDTH);
  localparam logic [SHW:0]     CNT_INIT = (SHW+1)'(WIDTH);

  state_t             state;
  logic [SHW:0]       count;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   divisor;
  logic               is_mod;
  logic               div_zero;
  logic               out_valid_q;
  logic               p_valid;
  logic [WIDTH-1:0]   p_result;
  logic               p_excep;
  logic               p_err;

  logic               accept;
  logic               is_div_op;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod;
  logic               shift_big;
  logic [WIDTH:0]     rem_sub;
  logic [WIDTH-1:0]   sc_result;
  logic               sc_excep;
  logic               sc_err;

  assign in_ready  = enable && !busy;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q && enable;
  assign is_div_op = (opcode == 4'h3) || (opcode == 4'h4);

  // Sign of the trial subtraction tells whether the shifted remainder covers the divisor.
  assign rem_sub = {rem, quo[WIDTH-1]} - {1'b0, divisor};

  always_comb begin
    sc_result = '0;
    sc_excep  = 1'b0;
    sc_err    = 1'b0;
    sum       = {1'b0, a} + {1'b0, b};
    diff      = {1'b0, a} - {1'b0, b};
    prod      = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    shift_big = (b >= W_VAL);
    case (opcode)
      4'h0: begin sc_result = sum[WIDTH-1:0];  sc_excep = sum[WIDTH];  end
      4'h1: begin sc_result = diff[WIDTH-1:0]; sc_excep = diff[WIDTH]; end
      4'h2: begin sc_result = prod[WIDTH-1:0]; sc_excep = |prod[2*WIDTH-1:WIDTH]; end
      4'h5: sc_result = a & b;
      4'h6: sc_result = a | b;
      4'h7: sc_result = a ^ b;
      4'h8: begin
        sc_result = shift_big ? '0 : (a << b[SHW-1:0]);
        sc_excep  = shift_big;
      end
      4'h9: begin
        sc_result = shift_big ? '0 : (a >> b[SHW-1:0]);
        sc_excep  = shift_big;
      end
      4'hA: sc_result = (a < b) ? a : b;
      4'hB: sc_result = (a < b) ? b : a;
      4'hC: sc_result = a;
      4'hD: sc_result = b;
      4'hE: sc_result = {{(WIDTH-1){1'b0}}, (a < b)};
      default: sc_err = (opcode == 4'hF);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      count       <= '0;
      quo         <= '0;
      rem         <= '0;
      divisor     <= '0;
      is_mod      <= 1'b0;
      div_zero    <= 1'b0;
      out_valid_q <= 1'b0;
      p_valid     <= 1'b0;
      p_result    <= '0;
      p_excep     <= 1'b0;
      p_err       <= 1'b0;
      result      <= '0;
      excep       <= 1'b0;
      err         <= 1'b0;
      busy        <= 1'b0;
    end else if (enable) begin
      out_valid_q <= 1'b0;
      p_valid     <= 1'b0;
      if (p_valid) begin
        result      <= p_result;
        excep       <= p_excep;
        err         <= p_err;
        out_valid_q <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (accept && is_div_op) begin
            is_mod  <= (opcode == 4'h4);
            divisor <= b;
            busy    <= 1'b1;
            if (b == '0) begin
              quo      <= '1;
              rem      <= a;
              div_zero <= 1'b1;
              state    <= S_DONE;
            end else begin
              quo      <= a;
              rem      <= '0;
              count    <= CNT_INIT;
              div_zero <= 1'b0;
              state    <= S_DIV;
            end
          end else if (accept) begin
            p_valid  <= 1'b1;
            p_result <= sc_result;
            p_excep  <= sc_excep;
            p_err    <= sc_err;
          end
        end
        S_DIV: begin
          if (!rem_sub[WIDTH]) begin
            rem <= rem_sub[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          count <= count - 1'b1;
          if (count == 1) state <= S_DONE;
        end
        S_DONE: begin
          result      <= is_mod ? rem : quo;
          excep       <= 1'b0;
          err         <= div_zero;
          out_valid_q <= 1'b1;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
